// File: rtl/subpel_output_collector_pkg.sv
// Shared types and defaults for the subpel output collector: pixel geometry,
// position encodings and the read-side FSM states.
package subpel_output_collector_pkg;

  localparam int NPIX_DEF  = 8;
  localparam int PIX_W_DEF = 8;
  localparam int ROWS_DEF  = 8;

  typedef enum logic [1:0] {
    POS_NONE = 2'd0,
    POS_A    = 2'd1,
    POS_B    = 2'd2,
    POS_C    = 2'd3
  } pos_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_e;

  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/subpel_output_collector_if.sv
// Capture-side and stream-side signals of the collector. The slave modport is
// the collector; the master modport is the interpolator/consumer pair.
interface subpel_output_collector_if
  import subpel_output_collector_pkg::*;
#(
  parameter int NPIX  = NPIX_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int ROWS  = ROWS_DEF
);
  localparam int DW = NPIX * PIX_W;
  localparam int RW = row_w(ROWS);

  logic          in_valid;
  logic          in_sync;
  logic [DW-1:0] fir_a;
  logic [DW-1:0] fir_b;
  logic [DW-1:0] fir_c;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_pos;
  logic [RW-1:0] out_row;
  logic          out_last;
  logic [1:0]    blocks_full;
  logic          overflow;

  modport master (
    output in_valid, in_sync, fir_a, fir_b, fir_c, out_ready,
    input  out_valid, out_data, out_pos, out_row, out_last, blocks_full, overflow
  );

  modport slave (
    input  in_valid, in_sync, fir_a, fir_b, fir_c, out_ready,
    output out_valid, out_data, out_pos, out_row, out_last, blocks_full, overflow
  );

endinterface

// File: rtl/subpel_output_collector_bank.sv
// One block buffer: ROWS rows for each of positions A/B/C, one write port that
// stores all three positions of a row, one asynchronous read port by (pos,row).
module collector_bank
  import subpel_output_collector_pkg::*;
#(
  parameter  int NPIX  = NPIX_DEF,
  parameter  int PIX_W = PIX_W_DEF,
  parameter  int ROWS  = ROWS_DEF,
  localparam int DW    = NPIX * PIX_W,
  localparam int RW    = row_w(ROWS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [RW-1:0] i_wr_row,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [DW-1:0] i_c,
  input  pos_e          i_rd_pos,
  input  logic [RW-1:0] i_rd_row,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem_a [ROWS];
  logic [DW-1:0] r_mem_b [ROWS];
  logic [DW-1:0] r_mem_c [ROWS];

  // NOTE: storage is deliberately left out of reset; a bank is only read after
  // every row has been rewritten, so its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem_a[i_wr_row] <= i_a;
      r_mem_b[i_wr_row] <= i_b;
      r_mem_c[i_wr_row] <= i_c;
    end
  end

  always_comb begin
    case (i_rd_pos)
      POS_A:   o_rd_data = r_mem_a[i_rd_row];
      POS_B:   o_rd_data = r_mem_b[i_rd_row];
      POS_C:   o_rd_data = r_mem_c[i_rd_row];
      default: o_rd_data = '0;
    endcase
  end

endmodule

// File: rtl/subpel_output_collector.sv
// Double-buffered collector: assembles A/B/C filter rows into 8x8 blocks and
// streams finished blocks out row by row without ever stalling the writer.
module subpel_output_collector
  import subpel_output_collector_pkg::*;
#(
  parameter int NPIX  = NPIX_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int ROWS  = ROWS_DEF
) (
  input logic                     clk,
  input logic                     rst,
  subpel_output_collector_if.slave bus
);

  localparam int DW = NPIX * PIX_W;
  localparam int RW = row_w(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  // write side
  logic          r_wr_bank;
  logic [RW-1:0] r_wr_row;
  logic [1:0]    r_full;
  logic          r_overflow;
  logic [1:0]    r_blocks_full;
  logic [RW-1:0] w_wr_row;
  logic          w_accept;
  logic          w_drop;
  logic          w_wr_last;
  logic [1:0]    w_we;
  logic [1:0]    w_full_set;
  logic [1:0]    w_full_clr;
  logic [1:0]    w_full_nxt;

  // read side
  rd_state_e     r_state,   w_nxt_state;
  logic          r_rd_bank, w_nxt_bank;
  pos_e          r_out_pos, w_nxt_pos;
  logic [RW-1:0] r_out_row, w_nxt_row;
  logic          r_out_valid, w_nxt_valid;
  logic [DW-1:0] r_out_data,  w_nxt_data;
  logic          r_out_last,  w_nxt_last;
  logic          w_load;
  logic          w_rd_done;
  logic [DW-1:0] w_bank_data [2];

  // A sync row restarts the block at row 0, overwriting any partial rows.
  assign w_wr_row   = bus.in_sync ? '0 : r_wr_row;
  assign w_accept   = bus.in_valid && !r_full[r_wr_bank];
  assign w_drop     = bus.in_valid &&  r_full[r_wr_bank];
  assign w_wr_last  = w_accept && (w_wr_row == LAST_ROW);
  assign w_full_set = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_full_clr = w_rd_done ? (2'b01 << r_rd_bank) : 2'b00;
  assign w_full_nxt = (r_full | w_full_set) & ~w_full_clr;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_we[b] = w_accept && (r_wr_bank == 1'(b));

    collector_bank #(.NPIX(NPIX), .PIX_W(PIX_W), .ROWS(ROWS)) u_bank (
      .clk       (clk),
      .i_we      (w_we[b]),
      .i_wr_row  (w_wr_row),
      .i_a       (bus.fir_a),
      .i_b       (bus.fir_b),
      .i_c       (bus.fir_c),
      .i_rd_pos  (w_nxt_pos),
      .i_rd_row  (w_nxt_row),
      .o_rd_data (w_bank_data[b])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank     <= 1'b0;
      r_wr_row      <= '0;
      r_full        <= 2'b00;
      r_overflow    <= 1'b0;
      r_blocks_full <= 2'd0;
    end else begin
      if (w_accept) begin
        r_wr_bank <= w_wr_last ? ~r_wr_bank : r_wr_bank;
        r_wr_row  <= w_wr_last ? '0 : w_wr_row + 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
      r_full        <= w_full_nxt;
      r_blocks_full <= {1'b0, w_full_nxt[0]} + {1'b0, w_full_nxt[1]};
    end
  end

  // Read FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RD_IDLE;
      r_rd_bank   <= 1'b0;
      r_out_pos   <= POS_NONE;
      r_out_row   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_rd_bank   <= w_nxt_bank;
      r_out_pos   <= w_nxt_pos;
      r_out_row   <= w_nxt_row;
      r_out_valid <= w_nxt_valid;
      r_out_data  <= w_nxt_data;
      r_out_last  <= w_nxt_last;
    end
  end

  // Read FSM: next state. The next (pos,row) doubles as the bank read address,
  // so the registered beat always matches the pointer it was fetched with.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_bank  = r_rd_bank;
    w_nxt_pos   = r_out_pos;
    w_nxt_row   = r_out_row;
    w_load      = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_nxt_state = RD_SEND;
          w_nxt_pos   = POS_A;
          w_nxt_row   = '0;
          w_load      = 1'b1;
        end
      end
      RD_SEND: begin
        if (bus.out_ready) begin
          if (r_out_last) begin
            w_rd_done  = 1'b1;
            w_nxt_bank = ~r_rd_bank;
            if (r_full[~r_rd_bank]) begin
              w_nxt_pos = POS_A;
              w_nxt_row = '0;
              w_load    = 1'b1;
            end else begin
              w_nxt_state = RD_IDLE;
              w_nxt_pos   = POS_NONE;
              w_nxt_row   = '0;
            end
          end else begin
            w_load = 1'b1;
            if (r_out_row == LAST_ROW) begin
              w_nxt_row = '0;
              w_nxt_pos = pos_e'(r_out_pos + 2'd1);
            end else begin
              w_nxt_row = r_out_row + 1'b1;
            end
          end
        end
      end
      default: w_nxt_state = RD_IDLE;
    endcase
  end

  // Read FSM: next outputs
  always_comb begin
    w_nxt_valid = (w_nxt_state == RD_SEND);
    w_nxt_last  = w_nxt_valid && (w_nxt_pos == POS_C) && (w_nxt_row == LAST_ROW);
    if (w_load)           w_nxt_data = w_bank_data[w_nxt_bank];
    else if (w_nxt_valid) w_nxt_data = r_out_data;
    else                  w_nxt_data = '0;
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_pos     = r_out_pos;
  assign bus.out_row     = r_out_row;
  assign bus.out_last    = r_out_last;
  assign bus.blocks_full = r_blocks_full;
  assign bus.overflow    = r_overflow;

endmodule
